// File: rtl/mem_access_if.sv
// mem_access_if: bus bundle between the LC-3 memory-access stage and its
// surroundings (controller request side, data memory side, writeback side).
//   start/op/ind/M_addr/M_data : request from execute/controller
//   Data_dout                  : data-memory read data
//   Data_addr/Data_din/Data_en/Data_rd : data-memory command
//   memout                     : loaded word towards the writeback mux
//   busy/done/done_load        : status towards the controller
// Modports: master = environment (controller + memory), slave = mem_access.
interface mem_access_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              start;
  logic [1:0]        op;
  logic              ind;
  logic [ADDR_W-1:0] M_addr;
  logic [DATA_W-1:0] M_data;
  logic [DATA_W-1:0] Data_dout;
  logic [ADDR_W-1:0] Data_addr;
  logic [DATA_W-1:0] Data_din;
  logic              Data_en;
  logic              Data_rd;
  logic [DATA_W-1:0] memout;
  logic              busy;
  logic              done;
  logic              done_load;

  modport master (
    output start, op, ind, M_addr, M_data, Data_dout,
    input  Data_addr, Data_din, Data_en, Data_rd, memout, busy, done, done_load
  );

  modport slave (
    input  start, op, ind, M_addr, M_data, Data_dout,
    output Data_addr, Data_din, Data_en, Data_rd, memout, busy, done, done_load
  );
endinterface

// File: rtl/mem_access.sv
// mem_access: LC-3 memory-access stage. Performs LD/LDR/LDI and ST/STR/STI
// data-memory transactions (indirect forms fetch a pointer first) against a
// synchronous-read memory, holds the last loaded word on memout, and pulses
// done/done_load for one cycle on completion.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mem_access_if.slave (request, memory command, status, memout)
module mem_access #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  mem_access_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    IRD,
    ICAP,
    RD,
    CAP,
    WR,
    FIN
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] memout_q;
  logic              load_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Datapath registers: request capture, pointer capture, load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      data_q   <= '0;
      memout_q <= '0;
      load_q   <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        addr_q <= bus.M_addr;
        data_q <= bus.M_data;
        load_q <= (bus.op == 2'b01);
      end
      if (state == ICAP) addr_q   <= bus.Data_dout;
      if (state == CAP)  memout_q <= bus.Data_dout;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            2'b01:   state_nx = bus.ind ? IRD : RD;
            2'b10:   state_nx = bus.ind ? IRD : WR;
            default: state_nx = FIN;
          endcase
        end
      end
      IRD:     state_nx = ICAP;
      // Only loads and stores reach ICAP, so !load_q means store
      ICAP:    state_nx = load_q ? RD : WR;
      RD:      state_nx = CAP;
      CAP:     state_nx = FIN;
      WR:      state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state and registers
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.done      = (state == FIN);
    bus.done_load = (state == FIN) && load_q;
    bus.Data_en   = (state == IRD) || (state == RD) || (state == WR);
    bus.Data_rd   = (state != WR);
    bus.Data_addr = addr_q;
    bus.Data_din  = data_q;
    bus.memout    = memout_q;
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_access #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Device memory (driven by the DUT) and reference memory (abstract model)
  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] ref_memout;

  logic [15:0] rd_log[$];
  logic [15:0] wr_addr_log[$];
  logic [15:0] wr_data_log[$];

  // Synchronous-read memory: read data valid the cycle after the request
  always @(posedge clk) begin
    if (bus.Data_en) begin
      if (bus.Data_rd) begin
        bus.Data_dout <= mem[bus.Data_addr];
        rd_log.push_back(bus.Data_addr);
      end else begin
        mem[bus.Data_addr] = bus.Data_din;
        wr_addr_log.push_back(bus.Data_addr);
        wr_data_log.push_back(bus.Data_din);
      end
    end
  end

  task automatic clear_logs();
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  function automatic int exp_lat(input logic [1:0] op, input logic ind);
    if (op == 2'b01) return ind ? 5 : 3;
    if (op == 2'b10) return ind ? 4 : 2;
    return 1;
  endfunction

  // Abstract transaction effect: returns effective address used
  task automatic ref_apply(input logic [1:0] op, input logic ind,
                           input logic [15:0] addr, input logic [15:0] data,
                           output logic [15:0] ea);
    ea = ind ? ref_mem[addr] : addr;
    if (op == 2'b01) ref_memout = ref_mem[ea];
    else if (op == 2'b10) ref_mem[ea] = data;
  endtask

  // Entered at #1 after a posedge with the DUT idle; returns in the done cycle
  task automatic run_op(input logic [1:0] op, input logic ind,
                        input logic [15:0] addr, input logic [15:0] data,
                        input bit inject, output int lat, output logic dl,
                        output bit busy_ok);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.ind    = ind;
    bus.M_addr = addr;
    bus.M_data = data;
    @(posedge clk); #1;
    bus.start  = inject;
    bus.op     = inject ? 2'b10 : 2'($urandom);
    bus.ind    = 1'($urandom);
    bus.M_addr = 16'($urandom);
    bus.M_data = 16'($urandom);
    lat = 1; busy_ok = 1'b1; dl = 1'b0;
    while (!bus.done && lat < 20) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat++;
    end
    if (!bus.busy) busy_ok = 1'b0;
    dl = bus.done_load;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.done_load !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: busy/done/done_load got %b%b%b expected 000",
               bus.busy, bus.done, bus.done_load);
    end
    checks++;
    if (bus.Data_en !== 1'b0 || bus.Data_rd !== 1'b1) begin
      failures++;
      $display("FAIL reset_mem_ctl: en/rd got %b%b expected 01", bus.Data_en, bus.Data_rd);
    end
    checks++;
    if (bus.memout !== 16'h0 || bus.Data_addr !== 16'h0 || bus.Data_din !== 16'h0) begin
      failures++;
      $display("FAIL reset_regs: memout/addr/din got %h/%h/%h expected 0000",
               bus.memout, bus.Data_addr, bus.Data_din);
    end
    ref_memout = 16'h0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_direct_load();
    int lat; logic dl; bit bok; logic [15:0] ea;
    poke(16'h3005, 16'hBEEF);
    clear_logs();
    run_op(2'b01, 1'b0, 16'h3005, 16'h1111, 1'b0, lat, dl, bok);
    ref_apply(2'b01, 1'b0, 16'h3005, 16'h1111, ea);
    checks++;
    if (lat != 3 || dl !== 1'b1 || !bok) begin
      failures++;
      $display("FAIL direct_load_timing: lat=%0d dl=%b busy_ok=%0d expected lat=3 dl=1 busy_ok=1",
               lat, dl, bok);
    end
    checks++;
    if (bus.memout !== 16'hBEEF) begin
      failures++;
      $display("FAIL direct_load_data: got %h expected BEEF", bus.memout);
    end
    checks++;
    if (rd_log.size() != 1 || wr_addr_log.size() != 0 || rd_log[0] !== 16'h3005) begin
      failures++;
      $display("FAIL direct_load_access: reads=%0d writes=%0d expected one read at 3005",
               rd_log.size(), wr_addr_log.size());
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL direct_load_idle: busy/done got %b%b expected 00", bus.busy, bus.done);
    end
  endtask

  task automatic test_indirect_load();
    int lat; logic dl; bit bok; logic [15:0] ea;
    poke(16'h4000, 16'h4100);
    poke(16'h4100, 16'h1234);
    clear_logs();
    run_op(2'b01, 1'b1, 16'h4000, 16'h0, 1'b0, lat, dl, bok);
    ref_apply(2'b01, 1'b1, 16'h4000, 16'h0, ea);
    checks++;
    if (lat != 5 || dl !== 1'b1 || !bok) begin
      failures++;
      $display("FAIL indirect_load_timing: lat=%0d dl=%b busy_ok=%0d expected lat=5 dl=1 busy_ok=1",
               lat, dl, bok);
    end
    checks++;
    if (bus.memout !== ref_memout) begin
      failures++;
      $display("FAIL indirect_load_data: got %h expected %h", bus.memout, ref_memout);
    end
    checks++;
    if (rd_log.size() != 2 || wr_addr_log.size() != 0) begin
      failures++;
      $display("FAIL indirect_load_count: reads=%0d writes=%0d expected 2/0",
               rd_log.size(), wr_addr_log.size());
    end else if (rd_log[0] !== 16'h4000 || rd_log[1] !== 16'h4100) begin
      checks++;
      failures++;
      $display("FAIL indirect_load_addrs: got %h,%h expected 4000,4100", rd_log[0], rd_log[1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_indirect_store();
    int lat; logic dl; bit bok; logic [15:0] ea;
    logic [15:0] prev;
    prev = bus.memout;
    poke(16'h2000, 16'h2FFF);
    clear_logs();
    run_op(2'b10, 1'b1, 16'h2000, 16'hA5A5, 1'b0, lat, dl, bok);
    ref_apply(2'b10, 1'b1, 16'h2000, 16'hA5A5, ea);
    checks++;
    if (lat != 4 || dl !== 1'b0 || !bok) begin
      failures++;
      $display("FAIL indirect_store_timing: lat=%0d dl=%b busy_ok=%0d expected lat=4 dl=0 busy_ok=1",
               lat, dl, bok);
    end
    checks++;
    if (wr_addr_log.size() != 1 || rd_log.size() != 1) begin
      failures++;
      $display("FAIL indirect_store_count: reads=%0d writes=%0d expected 1/1",
               rd_log.size(), wr_addr_log.size());
    end else if (wr_addr_log[0] !== 16'h2FFF || wr_data_log[0] !== 16'hA5A5) begin
      checks++;
      failures++;
      $display("FAIL indirect_store_write: got %h@%h expected A5A5@2FFF",
               wr_data_log[0], wr_addr_log[0]);
    end
    checks++;
    if (mem[16'h2000] !== 16'h2FFF || mem[16'h2FFF] !== 16'hA5A5 || bus.memout !== prev) begin
      failures++;
      $display("FAIL indirect_store_state: ptr=%h tgt=%h memout=%h expected 2FFF/A5A5/%h",
               mem[16'h2000], mem[16'h2FFF], bus.memout, prev);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat; logic dl; bit bok; logic [15:0] ea;
    poke(16'h3100, 16'hCAFE);
    clear_logs();
    run_op(2'b01, 1'b0, 16'h3100, 16'h0, 1'b1, lat, dl, bok);
    ref_apply(2'b01, 1'b0, 16'h3100, 16'h0, ea);
    checks++;
    if (lat != 3 || bus.memout !== 16'hCAFE || wr_addr_log.size() != 0) begin
      failures++;
      $display("FAIL busy_ignore: lat=%0d memout=%h writes=%0d expected 3/CAFE/0",
               lat, bus.memout, wr_addr_log.size());
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: busy got %b expected 0", bus.busy);
    end
    clear_logs();
    run_op(2'b10, 1'b0, 16'h3200, 16'h5A5A, 1'b0, lat, dl, bok);
    ref_apply(2'b10, 1'b0, 16'h3200, 16'h5A5A, ea);
    checks++;
    if (lat != 2 || dl !== 1'b0 || mem[16'h3200] !== 16'h5A5A || wr_addr_log.size() != 1) begin
      failures++;
      $display("FAIL b2b_store: lat=%0d dl=%b mem=%h writes=%0d expected 2/0/5A5A/1",
               lat, dl, mem[16'h3200], wr_addr_log.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    int lat; logic dl; bit bok; logic [15:0] ea;
    bit saw_done;
    poke(16'h0010, 16'h1111);
    clear_logs();
    bus.start = 1'b1; bus.op = 2'b10; bus.ind = 1'b0;
    bus.M_addr = 16'h0010; bus.M_data = 16'h9999;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.Data_en !== 1'b1 || bus.Data_rd !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_wr: en/rd got %b%b expected 10", bus.Data_en, bus.Data_rd);
    end
    rst = 1'b1;
    #1;
    ref_memout = 16'h0;
    checks++;
    if (bus.busy !== 1'b0 || bus.Data_en !== 1'b0 || bus.Data_rd !== 1'b1 || bus.done !== 1'b0 ||
        bus.memout !== 16'h0 || bus.Data_addr !== 16'h0 || bus.Data_din !== 16'h0) begin
      failures++;
      $display("FAIL abort_outputs: busy=%b en=%b rd=%b done=%b memout=%h addr=%h din=%h expected 0 0 1 0 0000 0000 0000",
               bus.busy, bus.Data_en, bus.Data_rd, bus.done, bus.memout, bus.Data_addr, bus.Data_din);
    end
    saw_done = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    rst = 1'b0;
    checks++;
    if (mem[16'h0010] !== 16'h1111 || wr_addr_log.size() != 0 || saw_done) begin
      failures++;
      $display("FAIL abort_no_write: mem=%h writes=%0d done_seen=%0d expected 1111/0/0",
               mem[16'h0010], wr_addr_log.size(), saw_done);
    end
    poke(16'hFFFF, 16'h7E57);
    clear_logs();
    run_op(2'b01, 1'b0, 16'hFFFF, 16'h0, 1'b0, lat, dl, bok);
    ref_apply(2'b01, 1'b0, 16'hFFFF, 16'h0, ea);
    checks++;
    if (lat != 3 || dl !== 1'b1 || bus.memout !== 16'h7E57) begin
      failures++;
      $display("FAIL post_reset_load: lat=%0d dl=%b memout=%h expected 3/1/7E57",
               lat, dl, bus.memout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_nop_ops();
    int lat; logic dl; bit bok; logic [15:0] prev;
    logic [1:0] ops [2];
    ops[0] = 2'b00;
    ops[1] = 2'b11;
    for (int unsigned k = 0; k < 2; k++) begin
      prev = bus.memout;
      clear_logs();
      run_op(ops[k], 1'($urandom), 16'($urandom), 16'($urandom), 1'b0, lat, dl, bok);
      checks++;
      if (lat != 1 || dl !== 1'b0 || bus.memout !== prev ||
          rd_log.size() != 0 || wr_addr_log.size() != 0) begin
        failures++;
        $display("FAIL nop_op%0d: lat=%0d dl=%b memout=%h accesses=%0d expected 1/0/%h/0",
                 ops[k], lat, dl, bus.memout, rd_log.size() + wr_addr_log.size(), prev);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int lat; logic dl; bit bok;
    logic [1:0]  op;
    logic        ind;
    logic [15:0] addr, data, ea;
    int exp_rd, exp_wr;
    for (int unsigned n = 0; n < 60; n++) begin
      op   = 2'($urandom_range(0, 3));
      ind  = 1'($urandom);
      addr = 16'($urandom);
      data = 16'($urandom);
      exp_rd = (op == 2'b01) ? (ind ? 2 : 1) : (op == 2'b10 && ind) ? 1 : 0;
      exp_wr = (op == 2'b10) ? 1 : 0;
      clear_logs();
      run_op(op, ind, addr, data, 1'b0, lat, dl, bok);
      ref_apply(op, ind, addr, data, ea);
      checks++;
      if (lat != exp_lat(op, ind) || dl !== (op == 2'b01) || !bok) begin
        failures++;
        $display("FAIL rand%0d_timing: op=%b ind=%b lat=%0d dl=%b busy_ok=%0d expected lat=%0d",
                 n, op, ind, lat, dl, bok, exp_lat(op, ind));
      end
      checks++;
      if (bus.memout !== ref_memout) begin
        failures++;
        $display("FAIL rand%0d_memout: got %h expected %h", n, bus.memout, ref_memout);
      end
      checks++;
      if (rd_log.size() != exp_rd || wr_addr_log.size() != exp_wr || mem[ea] !== ref_mem[ea]) begin
        failures++;
        $display("FAIL rand%0d_mem: reads=%0d writes=%0d mem[%h]=%h expected %0d/%0d/%h",
                 n, rd_log.size(), wr_addr_log.size(), ea, mem[ea], exp_rd, exp_wr, ref_mem[ea]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.ind    = 1'b0;
    bus.M_addr = 16'h0;
    bus.M_data = 16'h0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    #2;
    test_reset();
    test_direct_load();
    test_indirect_load();
    test_indirect_store();
    test_back_to_back();
    test_reset_mid_op();
    test_nop_ops();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
